// File: rtl/jk_sequence_driver.sv
// ----------------------------------------------------------------------------
// jk_sequence_driver
//
// Purpose: stimulus-and-check engine for a JK flip-flop. On start it holds the
// attached flip-flop in reset, drives the canonical hold/reset/set/toggle J/K
// sequence (one APPLY cycle per step, separated by J=K=0 CHECK cycles),
// compares Q against an internal JK reference bit after every step, and
// reports a pass/fail verdict, a saturating error count and the index of the
// first failing check.
//
// Parameters:
//   RST_CYCLES  cycles dut_reset is held high (1..15)
//   ERR_W       width of err_count (saturating)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset of this block
//   start       in   begin a run; only looked at in IDLE or DONE
//   Q           in   flip-flop output under test
//   dut_reset   out  reset drive to the flip-flop
//   J, K        out  flip-flop data inputs
//   busy        out  run in progress
//   done        out  run complete, verdict valid
//   pass        out  done with zero mismatches
//   err_count   out  number of mismatching checks
//   first_fail  out  index of first failing check (0 = init, 1..8 = steps
//                    0..7, 15 = none)
// ----------------------------------------------------------------------------
module jk_sequence_driver #(
  parameter int RST_CYCLES = 2,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Q,
  output logic             dut_reset,
  output logic             J,
  output logic             K,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUT_RST,
    S_INIT_CHK,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] RST_LAST  = 4'(RST_CYCLES - 1);
  localparam logic [3:0] FF_NONE   = 4'd15;

  // (J,K) applied at each step of the run.
  function automatic logic [1:0] step_jk(input logic [2:0] step);
    logic [1:0] jk;
    case (step)
      3'd0:    jk = 2'b00;
      3'd1:    jk = 2'b01;
      3'd2:    jk = 2'b10;
      3'd3:    jk = 2'b11;
      3'd4:    jk = 2'b00;
      3'd5:    jk = 2'b11;
      3'd6:    jk = 2'b01;
      default: jk = 2'b11;
    endcase
    return jk;
  endfunction

  // JK characteristic equation used as the reference model.
  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    logic n;
    case (jk)
      2'b01:   n = 1'b0;
      2'b10:   n = 1'b1;
      2'b11:   n = ~q;
      default: n = q;
    endcase
    return n;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] e);
    logic [ERR_W-1:0] r;
    if (&e) r = e;
    else    r = e + ERR_W'(1);
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic             exp_q, exp_d;
  logic             dut_reset_q, dut_reset_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       ff_q, ff_d;

  logic             chk_en;
  logic             chk_exp;
  logic [3:0]       chk_idx;
  logic [1:0]       jk_d;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    rcnt_d      = rcnt_q;
    exp_d       = exp_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    ff_d        = ff_q;
    chk_en      = 1'b0;
    chk_exp     = 1'b0;
    chk_idx     = 4'd0;
    jk_d        = 2'b00;
    dut_reset_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DUT_RST;
          rcnt_d  = 4'd0;
          err_d   = '0;
          ff_d    = FF_NONE;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_DUT_RST: begin
        exp_d = 1'b0;
        if (rcnt_q == RST_LAST) state_d = S_INIT_CHK;
        else                    rcnt_d  = rcnt_q + 4'd1;
      end
      S_INIT_CHK: begin
        chk_en  = 1'b1;
        chk_exp = 1'b0;
        chk_idx = 4'd0;
        step_d  = 3'd0;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        // The flip-flop samples J/K at this cycle-ending edge; the model
        // advances at the same edge.
        exp_d   = jk_next(exp_q, step_jk(step_q));
        state_d = S_CHECK;
      end
      S_CHECK: begin
        chk_en  = 1'b1;
        chk_exp = exp_q;
        chk_idx = {1'b0, step_q} + 4'd1;
        if (step_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (chk_en && (Q != chk_exp)) begin
      err_d = sat_inc(err_q);
      if (ff_q == FF_NONE) ff_d = chk_idx;
    end

    // Verdict is taken from the count including the final check.
    if (state_q == S_CHECK && state_d == S_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = (err_d == '0);
    end

    // Outputs are registered from the next state so they are valid for the
    // whole cycle of that state. J/K are only non-zero during APPLY.
    dut_reset_d = (state_d == S_DUT_RST);
    if (state_d == S_APPLY) jk_d = step_jk(step_d);
    j_d = jk_d[1];
    k_d = jk_d[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      rcnt_q      <= 4'd0;
      exp_q       <= 1'b0;
      dut_reset_q <= 1'b0;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ff_q        <= FF_NONE;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rcnt_q      <= rcnt_d;
      exp_q       <= exp_d;
      dut_reset_q <= dut_reset_d;
      j_q         <= j_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      ff_q        <= ff_d;
    end
  end

  assign dut_reset  = dut_reset_q;
  assign J          = j_q;
  assign K          = k_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule
